// File: rtl/run_fsm.sv
// Multi-channel run detector/framer: per-channel IDLE/ARM/RUN/STOP FSM with glitch rejection,
// a post-run low guard and end-of-run pulses. Define RUN_FSM_RUNLEN_EN to add run-length capture.
module run_fsm #(
    parameter int CH       = 4,
    parameter int CW       = 8,
    parameter int MIN_HIGH = 2,
    parameter int STOP_LEN = 3
) (
    input  logic                 clk,
    input  logic                 ar,
    input  logic [CH-1:0]        x,
    output logic [CH-1:0]        f,
    output logic [CH-1:0]        done
`ifdef RUN_FSM_RUNLEN_EN
    ,
    output logic [CH*CW-1:0]     run_len
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic [CW-1:0] C_MIN_HIGH = CW'(MIN_HIGH);
    localparam logic [CW-1:0] C_STOP_LEN = CW'(STOP_LEN);
    localparam logic [CW-1:0] C_ONE      = CW'(1);
`ifdef RUN_FSM_RUNLEN_EN
    localparam logic [CW-1:0] C_LEN_MAX  = '1;
`endif

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t        r_state;
        logic [CW-1:0] r_cnt;
        logic          r_f;
        logic          r_done;
        logic          w_x;
        logic [CW-1:0] w_cnt_inc;
`ifdef RUN_FSM_RUNLEN_EN
        logic [CW-1:0] r_len;
        logic [CW-1:0] r_run_len;
        assign run_len[g*CW +: CW] = r_run_len;
`endif

        assign w_x       = x[g];
        assign w_cnt_inc = r_cnt + C_ONE;
        assign f[g]      = r_f;
        assign done[g]   = r_done;

        always_ff @(posedge clk or posedge ar) begin
            if (ar) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_f       <= 1'b0;
                r_done    <= 1'b0;
`ifdef RUN_FSM_RUNLEN_EN
                r_len     <= '0;
                r_run_len <= '0;
`endif
            end else begin
                // NOTE: non-blocking throughout; the default below is overridden later in the same edge.
                r_done <= 1'b0;
                case (r_state)
                    IDLE: begin
                        if (w_x) begin
                            if (MIN_HIGH == 1) begin
                                r_state <= RUN;
                                r_f     <= 1'b1;
`ifdef RUN_FSM_RUNLEN_EN
                                r_len   <= C_ONE;
`endif
                            end else begin
                                r_state <= ARM;
                                r_cnt   <= C_ONE;
                            end
                        end
                    end
                    ARM: begin
                        if (!w_x) begin
                            r_state <= IDLE;
                        end else if (w_cnt_inc == C_MIN_HIGH) begin
                            r_state <= RUN;
                            r_f     <= 1'b1;
`ifdef RUN_FSM_RUNLEN_EN
                            r_len   <= C_MIN_HIGH;
`endif
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    RUN: begin
                        if (w_x) begin
`ifdef RUN_FSM_RUNLEN_EN
                            if (r_len != C_LEN_MAX) r_len <= r_len + C_ONE;
`endif
                        end else begin
                            r_state   <= STOP;
                            r_cnt     <= '0;
                            r_f       <= 1'b0;
                            r_done    <= 1'b1;
`ifdef RUN_FSM_RUNLEN_EN
                            r_run_len <= r_len;
`endif
                        end
                    end
                    STOP: begin
                        // A high level only restarts the guard interval.
                        if (w_x) begin
                            r_cnt <= '0;
                        end else if (w_cnt_inc == C_STOP_LEN) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_f     <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_run_fsm.sv
// Scoreboard bench for run_fsm: a behavioural per-channel model pushes expected outputs for each
// driven sample; they are popped and compared one cycle later, with directed constant checks on top.
module tb_run_fsm;

    localparam int CH       = 4;
    localparam int CW       = 4;
    localparam int MIN_HIGH = 2;
    localparam int STOP_LEN = 3;
    localparam int RL_MAX   = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              ar;
    logic [CH-1:0]     x;
    logic [CH-1:0]     f;
    logic [CH-1:0]     done;
`ifdef RUN_FSM_RUNLEN_EN
    logic [CH*CW-1:0]  run_len;
`endif

    typedef struct {
        logic [CH-1:0]    f;
        logic [CH-1:0]    done;
        logic [CH*CW-1:0] rl;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Model: phase 0 idle, 1 qualifying, 2 running, 3 guard.
    int               m_ph[CH];
    int               m_hc[CH];
    int               m_lc[CH];
    logic [CH-1:0]    m_f;
    logic [CH-1:0]    m_done;
    logic [CH*CW-1:0] m_rl;

    run_fsm #(
        .CH(CH), .CW(CW), .MIN_HIGH(MIN_HIGH), .STOP_LEN(STOP_LEN)
    ) u_dut (
        .clk  (clk),
        .ar   (ar),
        .x    (x),
        .f    (f),
        .done (done)
`ifdef RUN_FSM_RUNLEN_EN
        ,
        .run_len(run_len)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_ph[i] = 0;
            m_hc[i] = 0;
            m_lc[i] = 0;
        end
        m_f    = '0;
        m_done = '0;
        m_rl   = '0;
    endtask

    task automatic model_step(input logic [CH-1:0] xv);
        for (int i = 0; i < CH; i++) begin
            m_done[i] = 1'b0;
            case (m_ph[i])
                0: if (xv[i]) begin
                    m_hc[i] = 1;
                    m_ph[i] = (m_hc[i] >= MIN_HIGH) ? 2 : 1;
                end
                1: if (!xv[i]) m_ph[i] = 0;
                   else begin
                       m_hc[i]++;
                       if (m_hc[i] >= MIN_HIGH) m_ph[i] = 2;
                   end
                2: if (xv[i]) m_hc[i]++;
                   else begin
                       m_ph[i]   = 3;
                       m_lc[i]   = 0;
                       m_done[i] = 1'b1;
                       m_rl[i*CW +: CW] = CW'((m_hc[i] > RL_MAX) ? RL_MAX : m_hc[i]);
                   end
                default: if (xv[i]) m_lc[i] = 0;
                   else begin
                       m_lc[i]++;
                       if (m_lc[i] >= STOP_LEN) m_ph[i] = 0;
                   end
            endcase
            m_f[i] = (m_ph[i] == 2);
        end
    endtask

    task automatic step(input logic [CH-1:0] xv, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        x = xv;
        model_step(xv);
        e.f    = m_f;
        e.done = m_done;
        e.rl   = m_rl;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, ".f"}, 32'(f), 32'(got.f));
        check({got.tag, ".done"}, 32'(done), 32'(got.done));
`ifdef RUN_FSM_RUNLEN_EN
        check({got.tag, ".run_len"}, 32'(run_len), 32'(got.rl));
`endif
    endtask

    initial begin
        logic [CH-1:0] xv;

        ar = 1'b1;
        x  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.f", 32'(f), 32'd0);
        check("reset.done", 32'(done), 32'd0);
`ifdef RUN_FSM_RUNLEN_EN
        check("reset.run_len", 32'(run_len), 32'd0);
`endif
        #2 ar = 1'b0;

        // Single-sample glitch on channel 0 must not qualify.
        step(4'b0001, "glitch_hi");
        step(4'b0000, "glitch_lo");
        step(4'b0000, "glitch_idle");
        step(4'b0001, "glitch_rearm");
        step(4'b0000, "glitch_lo2");

        // Normal five-sample run on channel 1.
        repeat (5) step(4'b0010, "run1_hi");
        check("run1_f_during", 32'(f[1]), 32'd1);
        step(4'b0000, "run1_rel");
        check("run1_done", 32'(done[1]), 32'd1);
`ifdef RUN_FSM_RUNLEN_EN
        check("run1_len5", 32'(run_len[1*CW +: CW]), 32'd5);
`endif
        repeat (3) step(4'b0000, "run1_guard");

        // Guard interval on channel 2: a high inside STOP restarts the count, no framing.
        repeat (3) step(4'b0100, "g_run");
        step(4'b0000, "g_rel");
        step(4'b0000, "g_lo1");
        step(4'b0100, "g_hi_in_stop");
        check("g_no_f", 32'(f[2]), 32'd0);
        step(4'b0000, "g_lo_a");
        step(4'b0000, "g_lo_b");
        step(4'b0100, "g_hi_early");
        check("g_early_no_f", 32'(f[2]), 32'd0);
        repeat (3) step(4'b0000, "g_lo_c");
        step(4'b0100, "g_requal1");
        step(4'b0100, "g_requal2");
        check("g_requal_f", 32'(f[2]), 32'd1);
        step(4'b0000, "g_rel2");
        repeat (3) step(4'b0000, "g_guard2");

        // Saturating length on channel 3.
        repeat (20) step(4'b1000, "sat_hi");
        step(4'b0000, "sat_rel");
        check("sat_done", 32'(done[3]), 32'd1);
`ifdef RUN_FSM_RUNLEN_EN
        check("sat_len15", 32'(run_len[3*CW +: CW]), 32'd15);
`endif
        repeat (3) step(4'b0000, "sat_guard");

        // All channels at once: staggered patterns, then random traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < CH; i++)
                xv[i] = (((t + 3 * i) % (4 + i)) < (2 + (i % 2)));
            step(xv, "indep_stag");
        end
        for (int t = 0; t < 80; t++) begin
            xv = CH'($urandom_range(0, (1 << CH) - 1));
            step(xv, "indep_rand");
        end

        // Asynchronous reset mid-run on channel 0, x held high throughout.
        repeat (5) step(4'b0000, "pre_rst_idle");
        repeat (3) step(4'b0001, "pre_rst_run");
        check("pre_rst_f0", 32'(f[0]), 32'd1);
        #2 ar = 1'b1;
        #1;
        check("async_rst.f", 32'(f), 32'd0);
        check("async_rst.done", 32'(done), 32'd0);
`ifdef RUN_FSM_RUNLEN_EN
        check("async_rst.run_len", 32'(run_len), 32'd0);
`endif
        model_reset();
        ar = 1'b0;
        step(4'b0001, "post_rst_arm");
        check("post_rst_f0_low", 32'(f[0]), 32'd0);
        step(4'b0001, "post_rst_run");
        check("post_rst_f0_high", 32'(f[0]), 32'd1);
        step(4'b0000, "post_rst_rel");
        repeat (3) step(4'b0000, "post_rst_guard");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/run_fsm.md
# run_fsm

Parametrised, multi-channel run detector and framer. Each of `CH` independent channels watches a serial level input `x`, qualifies a high run once it lasts `MIN_HIGH` consecutive samples, and holds the framing output `f` high while the run lasts. After the run it enforces a `STOP_LEN`-cycle low guard before re-arming. It is the next-generation replacement for the single-channel Idle/Start/Stop detector: it adds glitch rejection, a guard interval, end-of-run pulses and optional run-length capture.

## Interface
Parameters:
- `CH`, 4: number of independent channels, ≥1.
- `CW`, 8: internal counter and run-length width, ≥2.
- `MIN_HIGH`, 2: consecutive high samples needed to qualify a run, 1..2^CW-1.
- `STOP_LEN`, 3: consecutive low samples required in STOP before returning to IDLE, 1..2^CW-1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `ar` in 1: reset, asynchronous, active-high.
- `x` in CH: per-channel serial input, sampled on the rising edge of `clk`.
- `f` out CH: per-channel framing output, registered. High only in RUN.
- `done` out CH: one-cycle pulse marking the end of a qualified run.
- `run_len` out CH*CW: per-channel captured length; channel i occupies bits [i*CW +: CW]. Present only with `RUN_FSM_RUNLEN_EN`.

## Operation
- Each channel has its own state (IDLE, ARM, RUN, STOP), a counter `cnt[CW-1:0]` and a length counter `len[CW-1:0]`. Channels never interact.
- IDLE:
  - x=1 and MIN_HIGH=1: go to RUN, len=1.
  - x=1 and MIN_HIGH>1: go to ARM, cnt=1.
  - x=0: stay in IDLE.
- ARM:
  - x=0: return to IDLE. This is glitch rejection: no `done` pulse, no capture.
  - x=1: cnt+1. When cnt+1 == MIN_HIGH, go to RUN with len=MIN_HIGH.
- RUN:
  - x=1: stay; len+1, saturating at 2^CW-1.
  - x=0: go to STOP, cnt=0, pulse `done` for one cycle, capture len into `run_len`.
- STOP:
  - x=1: stay, cnt=0. A high level in STOP neither restarts nor extends the run.
  - x=0: cnt+1. When cnt+1 == STOP_LEN, go to IDLE.
- Illegal or unreachable state encoding: return to IDLE on the next edge with f=0 and done=0.
- Run length counts every high sample of the qualified run, including the ARM samples.

## Timing
- Reset values, all channels: state=IDLE, f=0, done=0, cnt=0, len=0, run_len=0.
- Reset mid-operation: outputs clear immediately, asynchronously. No `done` pulse is produced and `run_len` is zeroed.
- Qualification latency: if x is first sampled high at edge k and stays high, f=1 after edge k+MIN_HIGH-1.
- Release latency: if x is sampled low at edge m while in RUN, f=0 and done=1 after edge m. done=0 again after edge m+1.
- `run_len` updates on the same edge as `done` and holds until the next `done` or reset.
- Earliest re-qualification after release: the earliest edge at which x can be sampled high in IDLE is m+STOP_LEN+1.

## Configuration
- Macro: `RUN_FSM_RUNLEN_EN`.
- Defined:
  - `len` counters and the `run_len` port exist.
  - Capture and saturation behave as specified above.
- Undefined:
  - No `run_len` port and no `len` registers.
  - `f`, `done` and all state behaviour are cycle-identical to the defined build.

## Test plan
- Reset: assert `ar` mid-RUN on channel 0 with x=1 -> f, done and run_len read 0 immediately. After release with x held high, f returns 1 two edges later (MIN_HIGH=2).
- Glitch reject: x0 high for 1 cycle, MIN_HIGH=2 -> f0 stays 0, no done, state back to IDLE.
- Normal run: x1 high for 5 cycles, then low -> f1 high for 4 cycles, starting after the 2nd high edge. done1 pulses once; run_len[1]=5.
- Guard: after release, x2 pattern low, high, low, low, low with STOP_LEN=3 -> remains in STOP until the 3rd consecutive low. No f2 during that window; the next high qualifies normally.
- Saturation (CW=4): x3 high for 20 cycles -> run_len[3]=15 at done.
- Independence: all four channels driven with staggered patterns simultaneously -> each channel matches its single-channel reference model cycle-for-cycle.
